data_memory_responder: RTL

DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

---
 rtl/mmio_pkg.sv | 44 ++++
 rtl/console_fifo.sv | 63 ++++++
 rtl/data_memory_responder.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_pkg
//  Description : Address map, STATUS bit layout and region decode for the
//                data memory responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package mmio_pkg;

    localparam logic [31:0] GPIO_ADDR         = 32'hFFFF_FF00;
    localparam logic [31:0] CONSOLE_DATA_ADDR = 32'hFFFF_FF04;
    localparam logic [31:0] STATUS_ADDR       = 32'hFFFF_FF08;
    localparam logic [31:0] CYCLES_ADDR       = 32'hFFFF_FF0C;

    localparam int STATUS_FULL_BIT     = 0;
    localparam int STATUS_EMPTY_BIT    = 1;
    localparam int STATUS_OVERFLOW_BIT = 2;
    localparam int STATUS_COUNT_LSB    = 4;
    localparam int STATUS_COUNT_MSB    = 11;

    typedef enum logic [2:0] {
        REGION_RAM     = 3'd0,
        REGION_GPIO    = 3'd1,
        REGION_CONSOLE = 3'd2,
        REGION_STATUS  = 3'd3,
        REGION_CYCLES  = 3'd4,
        REGION_NONE    = 3'd5
    } region_e;

    // Byte-lane bits are ignored; RAM occupies [0, ram_bytes).
    function automatic region_e decode_region(input logic [31:0] addr,
                                              input logic [31:0] ram_bytes);
        region_e region;
        if (addr < ram_bytes)                             region = REGION_RAM;
        else if (addr[31:2] == GPIO_ADDR[31:2])           region = REGION_GPIO;
        else if (addr[31:2] == CONSOLE_DATA_ADDR[31:2])   region = REGION_CONSOLE;
        else if (addr[31:2] == STATUS_ADDR[31:2])         region = REGION_STATUS;
        else if (addr[31:2] == CYCLES_ADDR[31:2])         region = REGION_CYCLES;
        else                                              region = REGION_NONE;
        return region;
    endfunction

endpackage
`default_nettype wire

// File: rtl/console_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : console_fifo
//  Description : Byte FIFO for the console transmit path; a push into a full
//                FIFO is accepted only when a pop happens in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module console_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               head
);

    localparam int                 c_ptr_w      = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]   c_full_count = (c_ptr_w + 1)'(DEPTH);

    logic [7:0]         r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_do_pop;
    logic               w_do_push;

    assign full      = (r_count == c_full_count);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head      = empty ? 8'h00 : r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clock) begin
        if (!reset && w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/data_memory_responder.sv
`default_nettype none
// ============================================================================
//  Module      : data_memory_responder
//  Description : Zero-latency data RAM plus MMIO (GPIO, console TX, STATUS,
//                free-running CYCLES). Console FIFO built when CONSOLE_FIFO_EN
//                is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_memory_responder
    import mmio_pkg::*;
#(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic        write_memory,
    output logic [31:0] read_data,
    output logic [7:0]  gpio_out,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready
);

    localparam int          c_ram_aw    = $clog2(RAM_WORDS);
    localparam logic [31:0] c_ram_bytes = 32'(RAM_WORDS * 4);

    logic [31:0]         r_ram [RAM_WORDS];
    logic [7:0]          r_gpio;
    logic [31:0]         r_cycles;
    logic [31:0]         w_status;
    logic [c_ram_aw-1:0] w_ram_idx;
    region_e             w_region;

    assign w_region  = decode_region(address, c_ram_bytes);
    assign w_ram_idx = address[c_ram_aw+1:2];
    assign gpio_out  = r_gpio;

    // RAM is deliberately outside reset so stores during reset still land.
    always_ff @(posedge clock) begin
        if (write_memory && (w_region == REGION_RAM)) begin
            r_ram[w_ram_idx] <= write_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_gpio   <= 8'h00;
            r_cycles <= 32'h0;
        end else begin
            r_cycles <= r_cycles + 32'd1;
            if (write_memory && (w_region == REGION_GPIO)) begin
                r_gpio <= write_data[7:0];
            end
        end
    end

`ifdef CONSOLE_FIFO_EN
    localparam int c_cnt_w = $clog2(FIFO_DEPTH) + 1;

    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_push;
    logic [c_cnt_w-1:0] w_count;
    logic [7:0]         w_head;
    logic               r_overflow;

    assign w_pop    = !w_empty && tx_ready;
    assign w_push   = write_memory && (w_region == REGION_CONSOLE);
    assign tx_valid = !w_empty;
    assign tx_data  = w_head;

    console_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_console_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (w_push),
        .push_data (write_data[7:0]),
        .pop       (w_pop),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count),
        .head      (w_head)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_push && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end else if (write_memory && (w_region == REGION_STATUS) &&
                     write_data[STATUS_OVERFLOW_BIT]) begin
            r_overflow <= 1'b0;
        end
    end

    always_comb begin
        w_status = 32'h0;
        w_status[STATUS_COUNT_MSB:STATUS_COUNT_LSB] = 8'(w_count);
        w_status[STATUS_OVERFLOW_BIT] = r_overflow;
        w_status[STATUS_EMPTY_BIT]    = w_empty;
        w_status[STATUS_FULL_BIT]     = w_full;
    end
`else
    logic w_unused_tx_ready;

    assign w_unused_tx_ready = tx_ready;
    assign tx_valid          = 1'b0;
    assign tx_data           = 8'h00;

    always_comb begin
        w_status = 32'h0;
        w_status[STATUS_EMPTY_BIT] = 1'b1;
    end
`endif

    always_comb begin
        read_data = 32'h0;
        case (w_region)
            REGION_RAM:    read_data = r_ram[w_ram_idx];
            REGION_GPIO:   read_data = {24'h0, r_gpio};
            REGION_STATUS: read_data = w_status;
            REGION_CYCLES: read_data = r_cycles;
            default:       read_data = 32'h0;
        endcase
    end

endmodule
`default_nettype wire
